// File: rtl/instr_mem_arb.sv
// Two-requester arbiter in front of a single-port instruction memory.
// The loader has priority; a starvation counter forces a fetch grant after MAX_WAIT denials.
module instr_mem_arb #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4,
    localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    output logic [CNT_W-1:0]  wait_cnt
);

    // Handshake: a requester holds req and its address/data until the cycle in
    // which gnt=1; that cycle is the transfer. A granted read returns rvalid=1
    // with rdata exactly one cycle later, and rdata is 0 whenever rvalid=0.

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic override;
    logic f_tag;
    logic l_tag;

    assign override = f_req && (wait_cnt == WAIT_MAX);

    always_comb begin
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        mem_wen = 1'b0;
        mem_a   = '0;
        mem_d   = '0;
        if (RESET_N) begin
            if (f_req && (override || !l_req)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
        if (f_gnt) begin
            mem_a = f_addr;
        end else if (l_gnt) begin
            mem_a   = l_addr;
            mem_d   = l_wdata;
            mem_wen = l_we;
        end
    end

    // Counts consecutive denied fetch cycles; any grant or withdrawal restarts it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_cnt <= '0;
        end else if (!f_req || f_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            f_tag <= 1'b0;
            l_tag <= 1'b0;
        end else begin
            f_tag <= f_gnt;
            l_tag <= l_gnt && !l_we;
        end
    end

    assign f_rvalid = f_tag;
    assign l_rvalid = l_tag;
    assign f_rdata  = f_tag ? mem_q : '0;
    assign l_rdata  = l_tag ? mem_q : '0;

endmodule

// File: tb/tb_instr_mem_arb.sv
// Bench for instr_mem_arb: registered memory model, priority/starvation reference
// model with shadow memory, and a queue-based read-response scoreboard.
module tb_instr_mem_arb;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          f_req, l_req, l_we;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          f_gnt, l_gnt, f_rvalid, l_rvalid, mem_wen;
    logic [DW-1:0] f_rdata, l_rdata, mem_d;
    logic [DW-1:0] mem_q;
    logic [AW-1:0] mem_a;
    logic [CW-1:0] wait_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    instr_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .wait_cnt(wait_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pattern(int i);
        return DW'(i * 40503) ^ 16'h5A5A;
    endfunction

    // ---------------- memory model (registered read) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit mem_ready = 1'b0;
    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= pattern(i);
            mem_ready <= 1'b1;
        end else if (mem_wen) begin
            mem[mem_a] <= mem_d;
        end
        mem_q <= mem[mem_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard producer ----------------
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit ref_ready = 1'b0;
    int denied = 0;
    bit last_f_gnt = 1'b0;
    bit last_l_gnt = 1'b0;
    logic [DW-1:0] f_exp_q[$];
    logic [DW-1:0] l_exp_q[$];
    int f_due_q[$];
    int l_due_q[$];

    always @(negedge CLK) begin
        bit efg, elg, ewen;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (!ref_ready) begin
            for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pattern(i);
            ref_ready = 1'b1;
        end
        efg = 1'b0; elg = 1'b0; ewen = 1'b0; ea = '0; ed = '0;
        if (RESET_N) begin
            // fetch wins if the loader is idle or fetch has waited its full allowance
            efg = f_req && (!l_req || denied >= MW);
            elg = l_req && !efg;
            if (efg) ea = f_addr;
            if (elg) begin ea = l_addr; ed = l_wdata; ewen = l_we; end
        end
        check("f_gnt", 32'(f_gnt), 32'(efg));
        check("l_gnt", 32'(l_gnt), 32'(elg));
        check("mem_wen", 32'(mem_wen), 32'(ewen));
        check("mem_a", 32'(mem_a), 32'(ea));
        check("mem_d", 32'(mem_d), 32'(ed));
        check("wait_cnt", 32'(wait_cnt), 32'(denied));
        if (efg) begin
            f_exp_q.push_back(ref_mem[f_addr]);
            f_due_q.push_back(cyc + 1);
        end
        if (elg && !l_we) begin
            l_exp_q.push_back(ref_mem[l_addr]);
            l_due_q.push_back(cyc + 1);
        end
        if (elg && l_we) ref_mem[l_addr] = l_wdata;
        if (RESET_N && f_req && !efg) denied = (denied < MW) ? denied + 1 : MW;
        else denied = 0;
        last_f_gnt = efg;
        last_l_gnt = elg;
    end

    // ---------------- monitor / scoreboard consumer ----------------
    always @(negedge CLK) begin
        bit fv, lv;
        if (!RESET_N) begin
            f_exp_q.delete(); f_due_q.delete();
            l_exp_q.delete(); l_due_q.delete();
        end
        fv = (f_due_q.size() > 0) && (f_due_q[0] == cyc);
        lv = (l_due_q.size() > 0) && (l_due_q[0] == cyc);
        check("f_rvalid", 32'(f_rvalid), 32'(fv));
        check("l_rvalid", 32'(l_rvalid), 32'(lv));
        if (fv) begin
            check("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
            void'(f_due_q.pop_front());
        end else begin
            check("f_rdata_idle", 32'(f_rdata), 32'h0);
        end
        if (lv) begin
            check("l_rdata", 32'(l_rdata), 32'(l_exp_q.pop_front()));
            void'(l_due_q.pop_front());
        end else begin
            check("l_rdata_idle", 32'(l_rdata), 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic loader(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        RESET_N = 1'b0;
        // requests asserted during reset must not be granted
        f_req = 1'b1; f_addr = 9'h00A;
        loader(1'b1, 9'h00B, 16'hDEAD);
        repeat (4) step();
        idle();
        RESET_N = 1'b1;
        repeat (3) step();

        // fetch-only stream at one address
        f_req = 1'b1; f_addr = 9'h005;
        repeat (3) step();
        idle();
        repeat (2) step();

        // continuous loader writes versus a waiting fetch
        loader(1'b1, 9'h010, 16'h1234);
        f_req = 1'b1; f_addr = 9'h020;
        for (int i = 0; i < 7; i++) begin
            step();
            if (last_f_gnt) f_req = 1'b0;
        end
        idle();
        step();

        // write then read back the top address
        loader(1'b1, 9'h1FF, 16'hBEEF);
        step();
        loader(1'b0, 9'h1FF, 16'h0000);
        step();
        idle();
        repeat (2) step();

        // fetch withdrawn mid-wait restarts the starvation count
        loader(1'b1, 9'h030, 16'h0F0F);
        f_req = 1'b1; f_addr = 9'h044;
        repeat (3) step();
        f_req = 1'b0;
        step();
        f_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_f_gnt) f_req = 1'b0;
        end
        idle();
        step();

        // reset asserted while a fetch response is pending
        f_req = 1'b1; f_addr = 9'h033;
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        loader(1'b0, 9'h012, 16'h0);
        repeat (3) step();
        idle();
        RESET_N = 1'b1;
        repeat (2) step();

        // randomized traffic honouring hold-until-grant
        for (int i = 0; i < 600; i++) begin
            if (!f_req || last_f_gnt) begin
                f_req = ($urandom_range(0, 99) < 70);
                f_addr = rand_addr();
            end else if ($urandom_range(0, 99) < 5) begin
                f_req = 1'b0;
            end
            if (!l_req || last_l_gnt) begin
                l_req = ($urandom_range(0, 99) < 60);
                l_we = 1'(($urandom_range(0, 1)));
                l_addr = rand_addr();
                l_wdata = DW'($urandom);
            end
            step();
        end
        idle();
        repeat (3) step();

        check("f_queue_drained", 32'(f_exp_q.size()), 32'h0);
        check("l_queue_drained", 32'(l_exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_arb.md
INSTR_MEM_ARB -- requirements
Module: instr_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, maximum consecutive cycles fetch is denied while requesting.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port f_req  input  1  CPU fetch read request.
REQ-007 SHALL have port f_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port f_gnt  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port f_rvalid  output  1  f_rdata valid.
REQ-010 SHALL have port f_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have port l_req  input  1  loader/debug request.
REQ-012 SHALL have port l_we  input  1  loader request is a write (1) or read (0).
REQ-013 SHALL have port l_addr  input  ADDR_W  loader address.
REQ-014 SHALL have port l_wdata  input  DATA_W  loader write data.
REQ-015 SHALL have port l_gnt  output  1  loader request accepted this cycle.
REQ-016 SHALL have port l_rvalid  output  1  l_rdata valid (loader reads only).
REQ-017 SHALL have port l_rdata  output  DATA_W  loader read data.
REQ-018 SHALL have port mem_wen  output  1  memory write enable, active-high.
REQ-019 SHALL have port mem_a  output  ADDR_W  memory address.
REQ-020 SHALL have port mem_d  output  DATA_W  memory write data.
REQ-021 SHALL have port mem_q  input  DATA_W  memory read data, registered, valid one cycle after address.

Function
REQ-022 SHALL grant at most one requester per cycle; gnt combinational from req, priority state.
REQ-023 SHALL give loader priority by default; fetch granted when l_req=0 or starvation override active.
REQ-024 SHALL keep wait_cnt: increment when f_req=1 and f_gnt=0; clear when f_gnt=1 or f_req=0; saturate at MAX_WAIT.
REQ-025 SHALL activate starvation override when wait_cnt==MAX_WAIT and f_req=1: fetch granted, loader denied that cycle.
REQ-026 SHALL drive mem_a/mem_d/mem_wen combinationally from granted request: fetch -> mem_a=f_addr, mem_wen=0; loader -> mem_a=l_addr, mem_d=l_wdata, mem_wen=l_we.
REQ-027 SHALL drive mem_wen=0, mem_a=0, mem_d=0 when no grant.
REQ-028 SHALL register a one-bit-per-requester response tag at grant; fetch grant or loader read grant in cycle N -> matching rvalid=1 in cycle N+1 with rdata=mem_q.
REQ-029 SHALL not assert l_rvalid for loader writes.
REQ-030 SHALL hold f_rdata/l_rdata at 0 when corresponding rvalid=0.
REQ-031 SHALL support back-to-back grants every cycle (throughput 1 access/cycle, read latency 1).
REQ-032 SHALL require requesters to hold req/addr/data stable until gnt; ungranted requests are not queued internally.
REQ-033 SHALL, on loader write then read to same address in consecutive cycles, return the new data (memory read-after-write ordering preserved; no bypass).

Reset
REQ-034 SHALL, with RESET_N=0, asynchronously clear wait_cnt and response tags: f_rvalid=0, l_rvalid=0, rdata=0.
REQ-035 SHALL suppress any rvalid pending from a grant in the cycle before reset assertion.
REQ-036 SHALL gate grants (f_gnt=l_gnt=0, mem_wen=0) while RESET_N=0.

Verification
REQ-037 Fetch only, f_addr=0x005 held 3 cycles -> f_gnt=1 each cycle, f_rvalid=1 cycles 2-4 with f_rdata=mem[5].
REQ-038 l_req (write 0x1234 @0x010) and f_req together, MAX_WAIT=4, loader continuous -> l_gnt cycles 1-4, f_gnt cycle 5, wait_cnt cleared, l_gnt cycle 6.
REQ-039 Loader write 0xBEEF @0x1FF, then loader read @0x1FF -> mem_wen=1 cycle 1, l_rvalid=1 cycle 3 with l_rdata=0xBEEF, no l_rvalid in cycle 2.
REQ-040 Fetch granted cycle N, RESET_N low in cycle N+1 before edge -> f_rvalid stays 0, all outputs 0 until release.
REQ-041 Idle (no requests) -> mem_wen=0, mem_a=0, all gnt/rvalid 0 every cycle.
REQ-042 f_req dropped at wait_cnt=3 then reasserted -> wait_cnt restarts at 0; override not taken until 4 further denied cycles.
